// File: rtl/spi_flash_read_cache_pkg.sv
// Shared definitions for the SPI flash read cache: FSM state encoding,
// index-width helper and statistics counter width.
package spi_flash_read_cache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FILL_REQ  = 2'd1,
    FILL_WAIT = 2'd2
  } state_t;

  localparam int unsigned DEFAULT_LINES = 16;
  localparam int unsigned DEFAULT_IDX_W = $clog2(DEFAULT_LINES);
  localparam int unsigned STATS_W       = 16;

  function automatic int unsigned idx_width(input int unsigned lines);
    return (lines < 2) ? 1 : $clog2(lines);
  endfunction

endpackage

// File: rtl/spi_flash_cache_array.sv
// Tag/valid/data storage for the direct-mapped flash read cache: combinational
// lookup, one write port and a single-cycle clear of every valid bit.
module spi_flash_cache_array
  import spi_flash_read_cache_pkg::*;
#(
  parameter int unsigned LINES  = 16,
  parameter int unsigned ADDR_W = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] lookup_address,
  output logic              hit,
  output logic [31:0]       lookup_data,
  input  logic              wr_en,
  input  logic              wr_set_valid,
  input  logic [ADDR_W-1:0] wr_address,
  input  logic [31:0]       wr_data,
  input  logic              clear_all
);

  localparam int unsigned IDX_W = idx_width(LINES);
  localparam int unsigned TAG_W = ADDR_W - IDX_W;

  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tags [LINES];
  logic [31:0]      data [LINES];

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [IDX_W-1:0] wr_idx;
  logic [TAG_W-1:0] wr_tag;

  assign lk_idx = lookup_address[IDX_W-1:0];
  assign lk_tag = lookup_address[ADDR_W-1:IDX_W];
  assign wr_idx = wr_address[IDX_W-1:0];
  assign wr_tag = wr_address[ADDR_W-1:IDX_W];

  always_comb begin
    hit         = valid[lk_idx] && (tags[lk_idx] == lk_tag);
    lookup_data = data[lk_idx];
  end

  // Clear has priority so an invalidate coinciding with a fill leaves the line invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (clear_all) begin
      valid <= '0;
    end else if (wr_en && wr_set_valid) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[wr_idx] <= wr_tag;
      data[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/spi_flash_read_cache.sv
// Direct-mapped one-word-per-line read cache in front of the SPI flash reader.
// Optional hit/miss counters are enabled with `define SPI_FLASH_CACHE_STATS_EN.
module spi_flash_read_cache
  import spi_flash_read_cache_pkg::*;
#(
  parameter int unsigned LINES  = 16,
  parameter int unsigned ADDR_W = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] cpu_word_address,
  input  logic              cpu_rstrb,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_rbusy,
  input  logic              invalidate,
  output logic [ADDR_W-1:0] fl_word_address,
  output logic              fl_rstrb,
  input  logic [31:0]       fl_rdata,
`ifdef SPI_FLASH_CACHE_STATS_EN
  input  logic              stats_clear,
  output logic [STATS_W-1:0] hit_count,
  output logic [STATS_W-1:0] miss_count,
`endif
  input  logic              fl_rbusy
);

  state_t      state;
  logic        inv_pending;
  logic        hit;
  logic [31:0] lookup_data;
  logic        lookup;
  logic        fill_done;
  logic        fill_set_valid;

  always_comb begin
    lookup         = (state == IDLE) && cpu_rstrb;
    fill_done      = (state == FILL_WAIT) && !fl_rbusy;
    fill_set_valid = !inv_pending && !invalidate;
  end

  spi_flash_cache_array #(
    .LINES  (LINES),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk            (clk),
    .rst_n          (rst_n),
    .lookup_address (cpu_word_address),
    .hit            (hit),
    .lookup_data    (lookup_data),
    .wr_en          (fill_done),
    .wr_set_valid   (fill_set_valid),
    .wr_address     (fl_word_address),
    .wr_data        (fl_rdata),
    .clear_all      (invalidate)
  );

  // fl_word_address doubles as the latched miss address used for the line fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      cpu_rdata       <= '0;
      cpu_rbusy       <= 1'b0;
      fl_rstrb        <= 1'b0;
      fl_word_address <= '0;
      inv_pending     <= 1'b0;
    end else begin
      fl_rstrb <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_rstrb) begin
            if (hit) begin
              cpu_rdata <= lookup_data;
            end else begin
              fl_word_address <= cpu_word_address;
              cpu_rbusy       <= 1'b1;
              fl_rstrb        <= 1'b1;
              state           <= FILL_REQ;
            end
          end
        end
        FILL_REQ: begin
          if (invalidate) inv_pending <= 1'b1;
          state <= FILL_WAIT;
        end
        FILL_WAIT: begin
          if (!fl_rbusy) begin
            cpu_rdata   <= fl_rdata;
            cpu_rbusy   <= 1'b0;
            inv_pending <= 1'b0;
            state       <= IDLE;
          end else if (invalidate) begin
            inv_pending <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPI_FLASH_CACHE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (stats_clear) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (lookup) begin
      if (hit && (hit_count != '1))
        hit_count <= hit_count + STATS_W'(1);
      if (!hit && (miss_count != '1))
        miss_count <= miss_count + STATS_W'(1);
    end
  end
`endif

endmodule
